// File: rtl/sa_rr_packet_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sa_arb_pkg
// Shared types and helpers for the round-robin packet arbiter and its picker.
//   sa_arb_state_e : arbiter FSM states (IDLE / LOCKED)
//   grant_w(n)     : width of an index able to address n requesters
//   mod_add(a,b,n) : (a+b) mod n for operands already below n
// ----------------------------------------------------------------------------
package sa_arb_pkg;

    typedef enum logic {
        SA_ARB_IDLE   = 1'b0,
        SA_ARB_LOCKED = 1'b1
    } sa_arb_state_e;

    // A single requester would still need a 1-bit index field.
    function automatic int grant_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Both operands are always below n, so one conditional subtract replaces
    // a general modulo and keeps the rotation logic small.
    function automatic int mod_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/sa_rr_packet_arbiter_if.sv
// ----------------------------------------------------------------------------
// sa_rr_packet_arbiter_if
// Bundles the requester-side and output-side handshake of the arbiter.
//   req_valid/req_ready/req_data/req_last : N_REQ upstream beat channels
//   out_valid/out_ready/out_data/out_last : single downstream beat channel
//   out_grant                             : source index of the output beat
//   busy                                  : packet in progress or beat held
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus downstream consumer)
// ----------------------------------------------------------------------------
interface sa_rr_packet_arbiter_if
    import sa_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    localparam int GRANT_W = grant_w(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic [GRANT_W-1:0]      out_grant;
    logic                    busy;

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_grant, busy
    );

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_grant, busy
    );

endinterface

// File: rtl/sa_rr_packet_arbiter_pick.sv
// ----------------------------------------------------------------------------
// sa_rr_pick
// Purely combinational rotating-priority picker.
//   req    : request vector, one bit per requester
//   ptr    : index holding highest priority this cycle
//   any    : at least one request is pending
//   winner : first requesting index scanning ptr, ptr+1, ... modulo N_REQ
//            (equals ptr when nothing is requested)
// ----------------------------------------------------------------------------
module sa_rr_pick
    import sa_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GRANT_W = grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               any,
    output logic [GRANT_W-1:0] winner
);

    // rot_idx[k] is the requester sitting k places after ptr; rot_req is the
    // request vector viewed in that rotated order.
    logic [GRANT_W-1:0] rot_idx [N_REQ];
    logic [N_REQ-1:0]   rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_idx[gi] = GRANT_W'(mod_add(int'(ptr), gi, N_REQ));
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    assign any = |req;

    // Scan from the far end so the nearest requester after ptr overwrites last.
    always_comb begin
        winner = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                winner = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/sa_rr_packet_arbiter.sv
// ----------------------------------------------------------------------------
// sa_rr_packet_arbiter
// Round-robin, packet-locking arbiter sharing one feed port among N_REQ
// requesters. A winner is chosen by rotating priority, keeps the grant until
// its last beat, and its beats pass through one registered output stage that
// sustains one beat per cycle.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : sa_rr_packet_arbiter_if.slave (request channels, output channel,
//           out_grant, busy)
// ----------------------------------------------------------------------------
module sa_rr_packet_arbiter
    import sa_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    sa_rr_packet_arbiter_if.slave  bus
);

    localparam int GRANT_W = grant_w(N_REQ);

    sa_arb_state_e      state_q,     state_d;
    logic [GRANT_W-1:0] ptr_q,       ptr_d;
    logic [GRANT_W-1:0] lock_id_q,   lock_id_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;
    logic [GRANT_W-1:0] out_grant_q, out_grant_d;

    logic               pick_any;
    logic [GRANT_W-1:0] pick_winner;
    logic               slot_free;
    logic [GRANT_W-1:0] sel;
    logic               sel_ok;
    logic [N_REQ-1:0]   ready_vec;
    logic               accept;

    sa_rr_pick #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // The output register can take a beat if empty or being drained now.
    assign slot_free = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_id_d   = lock_id_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_grant_d = out_grant_q;
        ready_vec   = '0;
        sel         = lock_id_q;
        sel_ok      = 1'b0;

        unique case (state_q)
            SA_ARB_IDLE: begin
                sel    = pick_winner;
                sel_ok = pick_any;
            end
            SA_ARB_LOCKED: begin
                // Locked owner keeps ready even while its valid is low, so
                // the others stay stalled until the packet finishes.
                sel    = lock_id_q;
                sel_ok = 1'b1;
            end
            default: begin
                sel_ok = 1'b0;
            end
        endcase

        // No beat is taken while reset is held; it would be dropped anyway.
        if (sel_ok && slot_free && !reset) begin
            ready_vec[sel] = 1'b1;
        end
        accept = bus.req_valid[sel] && ready_vec[sel];

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.req_data[int'(sel)*DATA_W +: DATA_W];
            out_last_d  = bus.req_last[sel];
            out_grant_d = sel;
            if (bus.req_last[sel]) begin
                state_d = SA_ARB_IDLE;
                ptr_d   = GRANT_W'(mod_add(int'(sel), 1, N_REQ));
            end else begin
                state_d   = SA_ARB_LOCKED;
                lock_id_d = sel;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SA_ARB_IDLE;
            ptr_q       <= '0;
            lock_id_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_grant_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_id_q   <= lock_id_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_grant_q <= out_grant_d;
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_grant = out_grant_q;
    assign bus.busy      = (state_q == SA_ARB_LOCKED) || out_valid_q;

endmodule

// File: tb/tb_sa_rr_packet_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sa_rr_packet_arbiter
// Directed bench for sa_rr_packet_arbiter. Requesters are modelled as packet
// queues; a behavioural arbiter model (priority pointer, lock owner, output
// register) predicts every output each cycle, and hand-computed grant and
// data sequences pin the model for each scenario.
// Beat data encoding: tag<<8 | requester<<4 | beat index.
// ----------------------------------------------------------------------------
module tb_sa_rr_packet_arbiter;
    import sa_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sa_rr_packet_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    sa_rr_packet_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } beat_t;

    beat_t src_q [N][$];
    bit    src_en [N];
    bit    fire   [N];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: -1 lock means no packet in progress.
    int          m_ptr  = 0;
    int          m_lock = -1;
    bit          m_ov   = 0;
    logic [31:0] m_od   = '0;
    bit          m_ol   = 0;
    int          m_og   = 0;

    int          log_g [$];
    logic [31:0] log_d [$];
    int          log_c [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Runs at the falling edge: compare DUT to model, log drained beats,
    // then advance the model with the inputs the next rising edge will see.
    task automatic monitor();
        int          cand;
        bit          slot;
        logic [N-1:0] exp_ready;
        cyc++;
        slot = !m_ov || bus.out_ready;
        cand = -1;
        if (m_lock >= 0) begin
            cand = m_lock;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (cand < 0 && bus.req_valid[j]) cand = j;
            end
        end
        exp_ready = '0;
        if (!reset && cand >= 0 && slot) exp_ready[cand] = 1'b1;

        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("out_data",  bus.out_data, m_od);
        chk("out_last",  32'(bus.out_last), 32'(m_ol));
        chk("out_grant", 32'(bus.out_grant), 32'(m_og));
        chk("busy",      32'(bus.busy), 32'((m_lock >= 0) || m_ov));

        if (!reset && bus.out_valid && bus.out_ready) begin
            log_g.push_back(int'(bus.out_grant));
            log_d.push_back(bus.out_data);
            log_c.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            fire[i] = !reset && bus.req_valid[i] && bus.req_ready[i];
        end

        if (reset) begin
            m_ptr = 0; m_lock = -1; m_ov = 0; m_od = '0; m_ol = 0; m_og = 0;
        end else if (exp_ready != '0 && bus.req_valid[cand]) begin
            m_ov = 1;
            m_od = bus.req_data[cand*DW +: DW];
            m_ol = bus.req_last[cand];
            m_og = cand;
            if (bus.req_last[cand]) begin
                m_lock = -1;
                m_ptr  = (cand + 1) % N;
            end else begin
                m_lock = cand;
            end
        end else if (m_ov && bus.out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic drive();
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*DW-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                v[i]          = 1'b1;
                d[i*DW +: DW] = src_q[i][0].d;
                l[i]          = src_q[i][0].last;
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
    endtask

    task automatic step();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
                if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                fire[i] = 0;
            end
        end
        drive();
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_pkt(input int id, input int len, input int tag);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.d    = 32'((tag << 8) | (id << 4) | b);
            bt.last = (b == len - 1);
            src_q[id].push_back(bt);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < 300) begin
            done = all_empty() && !bus.out_valid;
            if (!done) begin
                step();
                n++;
            end
        end
        chk({name, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic clear_log();
        log_g.delete();
        log_d.delete();
        log_c.delete();
    endtask

    task automatic check_grants(input string name, input int e[$]);
        chk({name, "_count"}, 32'(log_g.size()), 32'(e.size()));
        for (int k = 0; k < e.size() && k < log_g.size(); k++) begin
            chk($sformatf("%s_grant[%0d]", name, k), 32'(log_g[k]), 32'(e[k]));
        end
    endtask

    task automatic check_back_to_back(input string name);
        for (int k = 1; k < log_c.size(); k++) begin
            chk($sformatf("%s_gap[%0d]", name, k), 32'(log_c[k] - log_c[k-1]), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e[$];
        logic [31:0] ed[$];

        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_en[i] = 1;
            fire[i]   = 0;
        end

        // Reset held two cycles with every requester valid.
        for (int i = 0; i < N; i++) push_pkt(i, 1, 1);
        drive();
        step();
        step();
        settle();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data, 32'd0);
        chk("rst_out_last",  32'(bus.out_last), 32'd0);
        chk("rst_out_grant", 32'(bus.out_grant), 32'd0);
        chk("rst_busy",      32'(bus.busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        drive();
        settle();
        chk("first_grant_ready", 32'(bus.req_ready), 32'b0001);
        clear_log();
        wait_drain("reset");
        e = '{0, 1, 2, 3};
        check_grants("reset", e);
        $display("txn reset: grants after release checked");

        // Fairness: continuous single-beat packets from all four.
        clear_log();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 1, 2);
        drive();
        wait_drain("fair");
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_grants("fair", e);
        check_back_to_back("fair");
        $display("txn fairness: 8 beats rotation checked");

        // Move ptr to 1, then requester 1 sends a 3-beat packet.
        push_pkt(0, 1, 3);
        drive();
        wait_drain("lock_pre");
        clear_log();
        push_pkt(1, 3, 3);
        push_pkt(0, 1, 3);
        push_pkt(2, 1, 3);
        push_pkt(3, 1, 3);
        drive();
        wait_drain("lock");
        e = '{1, 1, 1, 2, 3, 0};
        check_grants("lock", e);
        check_back_to_back("lock");
        $display("txn lock: 3-beat packet held grant");

        // Locked requester drops valid after its first beat: others stall.
        clear_log();
        push_pkt(1, 3, 5);
        push_pkt(0, 1, 5);
        push_pkt(2, 1, 5);
        push_pkt(3, 1, 5);
        drive();
        step();
        src_en[1] = 0;
        drive();
        settle();
        chk("stall_ready_0", 32'(bus.req_ready), 32'b0010);
        for (int s = 1; s <= 3; s++) begin
            step();
            settle();
            chk($sformatf("stall_ready_%0d", s), 32'(bus.req_ready), 32'b0010);
            chk($sformatf("stall_out_valid_%0d", s), 32'(bus.out_valid), 32'd0);
        end
        src_en[1] = 1;
        drive();
        wait_drain("stall");
        e = '{1, 1, 1, 2, 3, 0};
        check_grants("stall", e);
        $display("txn lock stall: others held off while owner idle");

        // Back-pressure for 5 cycles mid-stream.
        clear_log();
        push_pkt(1, 2, 4);
        push_pkt(2, 2, 4);
        push_pkt(3, 2, 4);
        push_pkt(0, 2, 4);
        drive();
        step();
        step();
        step();
        bus.out_ready = 1'b0;
        drive();
        for (int s = 0; s < 5; s++) begin
            settle();
            chk($sformatf("bp_data_%0d", s), bus.out_data, 32'h0420);
            chk($sformatf("bp_valid_%0d", s), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_ready_%0d", s), 32'(bus.req_ready), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        drive();
        wait_drain("bp");
        e  = '{1, 1, 2, 2, 3, 3, 0, 0};
        check_grants("bp", e);
        ed = '{32'h0410, 32'h0411, 32'h0420, 32'h0421,
               32'h0430, 32'h0431, 32'h0400, 32'h0401};
        chk("bp_data_count", 32'(log_d.size()), 32'(ed.size()));
        for (int k = 0; k < ed.size() && k < log_d.size(); k++) begin
            chk($sformatf("bp_data[%0d]", k), log_d[k], ed[k]);
        end
        $display("txn back-pressure: no beat lost or duplicated");

        // Sole requester 3: first from ptr=1, then from ptr=0 twice.
        clear_log();
        for (int r = 0; r < 3; r++) begin
            push_pkt(3, 1, 6);
            drive();
            wait_drain($sformatf("wrap_%0d", r));
        end
        push_pkt(0, 1, 6);
        push_pkt(3, 1, 6);
        drive();
        wait_drain("wrap_final");
        e = '{3, 3, 3, 0, 3};
        check_grants("wrap", e);
        $display("txn wrap: sole requester re-granted, ptr wrapped");

        // Reset during beat 2 of a 4-beat packet after ptr moved to 2.
        push_pkt(1, 1, 7);
        drive();
        wait_drain("rstmid_pre");
        clear_log();
        push_pkt(2, 4, 8);
        drive();
        step();
        reset = 1'b1;
        step();
        settle();
        chk("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rstmid_busy",      32'(bus.busy), 32'd0);
        chk("rstmid_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        src_q[2].delete();
        push_pkt(1, 1, 9);
        push_pkt(3, 1, 9);
        drive();
        settle();
        chk("rstmid_grant_ptr0", 32'(bus.req_ready), 32'b0010);
        wait_drain("rstmid");
        e = '{1, 3};
        check_grants("rstmid", e);
        $display("txn reset mid-packet: lock dropped, ptr restarted at 0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
